cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception receiver for the five-stage pipeline, located at the M stage. It consumes the prioritized 5-bit exception code produced by the per-stage code-merging chain, along with hardware interrupt lines. When an event is accepted it raises a single-cycle flush/redirect request, and it records the event state in the SR, Cause and EPC registers. It also services mfc0/mtc0 accesses and eret.

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/cp0_exc_ctrl.sv | 116 +++++++++++
 tb/tb_cp0_exc_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, bit positions, defaults.
package cp0_pkg;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR bit positions
  localparam int unsigned SR_IE_BIT  = 0;
  localparam int unsigned SR_EXL_BIT = 1;
  localparam int unsigned SR_IM_LO   = 10;
  localparam int unsigned SR_IM_HI   = 15;

  // Cause bit positions
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD_BIT = 31;

  // EPC is word aligned
  localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

  localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEF_PRID_VAL   = 32'h0000_4C34;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception receiver at the M stage: accepts exceptions/interrupts, raises a
// one-cycle redirect, keeps SR/Cause/EPC and services mfc0/mtc0/eret.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] PRID_VAL   = DEF_PRID_VAL
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  exc_code,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic int_req;
  logic exc_accept;

  assign int_req    = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_accept = ~sr_exl_q & (int_req | (exc_code != EXC_INT));

  assign exc_req    = exc_accept;
  assign handler_pc = HANDLER_PC;
  assign epc_out    = epc_q;

  // Next-state: accept wins outright; otherwise mtc0 lands and eret then clears EXL.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    cause_ip_d  = hw_int;
    epc_d       = epc_q;
    if (exc_accept) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? EXC_INT : exc_code;
      cause_bd_d  = bd_m;
      epc_d       = (bd_m ? (pc_m - 32'd4) : pc_m) & EPC_MASK;
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          CP0_SR: begin
            sr_im_d  = cp0_wdata[SR_IM_HI:SR_IM_LO];
            sr_exl_d = cp0_wdata[SR_EXL_BIT];
            sr_ie_d  = cp0_wdata[SR_IE_BIT];
          end
          CP0_EPC: epc_d = cp0_wdata & EPC_MASK;
          default: ;
        endcase
      end
      if (eret_m) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // CP0 state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 read mux, unimplemented bits read as zero
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR: begin
        cp0_rdata[SR_IM_HI:SR_IM_LO] = sr_im_q;
        cp0_rdata[SR_EXL_BIT]        = sr_exl_q;
        cp0_rdata[SR_IE_BIT]         = sr_ie_q;
      end
      CP0_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]              = cause_bd_q;
        cp0_rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip_q;
        cp0_rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc_q;
      end
      CP0_EPC:  cp0_rdata = epc_q;
      CP0_PRID: cp0_rdata = PRID_VAL;
      default:  cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  exc_code;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret_m;
  logic [31:0] cp0_rdata;
  logic        exc_req;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;

  int checks = 0;
  int failures = 0;

  cp0_exc_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .exc_code  (exc_code),
    .pc_m      (pc_m),
    .bd_m      (bd_m),
    .hw_int    (hw_int),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .eret_m    (eret_m),
    .cp0_rdata (cp0_rdata),
    .exc_req   (exc_req),
    .handler_pc(handler_pc),
    .epc_out   (epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic idle();
    exc_code  = 5'd0;
    bd_m      = 1'b0;
    cp0_we    = 1'b0;
    cp0_wdata = 32'h0;
    eret_m    = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    pc_m = 32'h0;
    hw_int = 6'd0;
    cp0_addr = 5'd0;
    idle();
    #3;
    chk("rst_exc_req", {31'b0, exc_req}, 32'h0);
    chk("rst_handler_pc", handler_pc, 32'h0000_4180);
    rd("rst_addr0", 5'd0, 32'h0);
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h0000_4C34);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // synchronous exception, not in a delay slot
    exc_code = 5'd12; pc_m = 32'h0000_3010; bd_m = 1'b0;
    #1 chk("ov_req", {31'b0, exc_req}, 32'h1);
    @(negedge clk);
    chk("ov_req_held", {31'b0, exc_req}, 32'h0);
    idle();
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_epc", 5'd14, 32'h0000_3010);
    chk("ov_epc_out", epc_out, 32'h0000_3010);
    rd("ov_sr", 5'd12, 32'h0000_0002);
    @(negedge clk);
    eret_m = 1'b1;
    @(negedge clk);
    idle();
    rd("eret_sr", 5'd12, 32'h0);

    // delay slot exception
    @(negedge clk);
    exc_code = 5'd4; pc_m = 32'h0000_3024; bd_m = 1'b1;
    #1 chk("bd_req", {31'b0, exc_req}, 32'h1);
    @(negedge clk);
    idle();
    rd("bd_epc", 5'd14, 32'h0000_3020);
    rd("bd_cause", 5'd13, 32'h8000_0010);

    // interrupt beats a synchronous code; mtc0 SR also clears EXL
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
    @(negedge clk);
    idle();
    rd("int_sr_set", 5'd12, 32'h0000_0401);
    @(negedge clk);
    hw_int = 6'b000001; exc_code = 5'd10; pc_m = 32'h0000_3100;
    #1 chk("int_req", {31'b0, exc_req}, 32'h1);
    @(negedge clk);
    chk("int_req_in_handler", {31'b0, exc_req}, 32'h0);
    idle();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_3100);

    // eret with mtc0 SR: write lands, EXL forced low; same-cycle read sees old value
    @(negedge clk);
    hw_int = 6'd0;
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_FC03; eret_m = 1'b1;
    #1 chk("eret_mtc0_req", {31'b0, exc_req}, 32'h0);
    chk("no_bypass_sr", cp0_rdata, 32'h0000_0403);
    @(negedge clk);
    idle();
    rd("eret_mtc0_sr", 5'd12, 32'h0000_FC01);

    // IM all clear: interrupt line alone does not request
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0001;
    @(negedge clk);
    idle();
    hw_int = 6'b000001;
    #1 chk("im0_req", {31'b0, exc_req}, 32'h0);
    @(negedge clk);
    hw_int = 6'd0;

    // accept suppresses same-cycle eret and mtc0
    @(negedge clk);
    exc_code = 5'd5; pc_m = 32'h0000_3200;
    eret_m = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_1234;
    #1 chk("sup_req", {31'b0, exc_req}, 32'h1);
    @(negedge clk);
    idle();
    rd("sup_epc", 5'd14, 32'h0000_3200);
    rd("sup_sr", 5'd12, 32'h0000_0003);
    rd("sup_cause", 5'd13, 32'h0000_0014);

    // Cause writes dropped, EPC write aligned
    @(negedge clk);
    cp0_we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    cp0_addr = 5'd14; cp0_wdata = 32'h0000_5677;
    @(negedge clk);
    idle();
    rd("cause_ro", 5'd13, 32'h0000_0014);
    rd("epc_wr", 5'd14, 32'h0000_5674);

    // pc_m - 4 wraps at zero
    @(negedge clk);
    eret_m = 1'b1;
    @(negedge clk);
    idle();
    exc_code = 5'd4; pc_m = 32'h0; bd_m = 1'b1;
    @(negedge clk);
    idle();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);

    // reset mid-handler: async clear, interrupts masked afterwards
    @(negedge clk);
    hw_int = 6'b000001;
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_req", {31'b0, exc_req}, 32'h0);
    rd("mid_rst_sr", 5'd12, 32'h0);
    rd("mid_rst_cause", 5'd13, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("post_rst_masked", {31'b0, exc_req}, 32'h0);
    rd("post_rst_ip", 5'd13, 32'h0000_0400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
